// File: rtl/cache_stats_counter.sv
// Cache statistics front end: stages I/D cache event pulses into live counters and publishes a snapshot with a print strobe.
// Build option: define STATS_SATURATE_EN to make live counters saturate at all-ones instead of wrapping.
module cache_stats_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ins_read_ev,
    input  logic             ins_hit_ev,
    input  logic             ins_miss_ev,
    input  logic             data_read_ev,
    input  logic             data_write_ev,
    input  logic             data_hit_ev,
    input  logic             data_miss_ev,
    input  logic             print_req,
    input  logic             clear_req,
    output logic             busy,
    output logic             print,
    output logic [CNT_W-1:0] ins_reads,
    output logic [CNT_W-1:0] ins_hit,
    output logic [CNT_W-1:0] ins_miss,
    output logic [CNT_W-1:0] data_reads,
    output logic [CNT_W-1:0] data_writes,
    output logic [CNT_W-1:0] data_hit,
    output logic [CNT_W-1:0] data_miss
);

    // state | meaning
    // IDLE  | counting, accepts print_req / immediate clear
    // DRAIN | staged events of the request cycle land in the live counters
    // SNAP  | snapshot loads from live counters at the end of this cycle
    // PRINT | print strobe high; a pending clear is applied at its end
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SNAP  = 2'd2,
        PRINT = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [6:0]       w_ev;
    logic [6:0]       r_stage;
    logic             r_clear_pend;
    logic             w_clear_now;
    logic             w_clear_defer;
    logic [CNT_W-1:0] r_live [7];
    logic [CNT_W-1:0] r_snap [7];

    assign w_ev = {data_miss_ev, data_hit_ev, data_write_ev, data_read_ev,
                   ins_miss_ev, ins_hit_ev, ins_read_ev};

    assign w_clear_now   = ((r_state == IDLE) && clear_req && !print_req) ||
                           ((r_state == PRINT) && (r_clear_pend || clear_req));
    assign w_clear_defer = clear_req && ((r_state != IDLE) || print_req);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (print_req) w_next_state = DRAIN;
            DRAIN:   w_next_state = SNAP;
            SNAP:    w_next_state = PRINT;
            PRINT:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state != IDLE);
        print = (r_state == PRINT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clear_pend <= 1'b0;
        end else if (w_clear_now) begin
            r_clear_pend <= 1'b0;
        end else if (w_clear_defer) begin
            r_clear_pend <= 1'b1;
        end
    end

    // A clear also flushes the stage, discarding the clear cycle and the one before it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stage <= '0;
        end else if (w_clear_now) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_ev;
        end
    end

    for (genvar g = 0; g < 7; g++) begin : g_live
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_live[g] <= '0;
            end else if (w_clear_now) begin
                r_live[g] <= '0;
            end else if (r_stage[g]) begin
`ifdef STATS_SATURATE_EN
                if (r_live[g] != '1) begin
                    r_live[g] <= r_live[g] + 1'b1;
                end
`else
                r_live[g] <= r_live[g] + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 7; i++) begin
                r_snap[i] <= '0;
            end
        end else if (r_state == SNAP) begin
            for (int i = 0; i < 7; i++) begin
                r_snap[i] <= r_live[i];
            end
        end
    end

    assign ins_reads   = r_snap[0];
    assign ins_hit     = r_snap[1];
    assign ins_miss    = r_snap[2];
    assign data_reads  = r_snap[3];
    assign data_writes = r_snap[4];
    assign data_hit    = r_snap[5];
    assign data_miss   = r_snap[6];

endmodule
